// File: rtl/exe_muldiv.sv
// RV32M multiply/divide unit: radix-2 shift-add multiply and restoring divide on operand
// magnitudes, with one-cycle shortcuts for divide-by-zero, signed overflow and optional fast multiply.
module exe_muldiv #(
  parameter int DATA_WIDTH  = 32,
  parameter int RADDR_WIDTH = 5,
  parameter bit FAST_MUL    = 1'b0
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic                   start_i,
  input  logic [2:0]             op_i,
  input  logic [DATA_WIDTH-1:0]  op1_i,
  input  logic [DATA_WIDTH-1:0]  op2_i,
  input  logic [RADDR_WIDTH-1:0] reg_waddr_i,
  input  logic                   flush_i,
  output logic                   busy_o,
  output logic                   stallreq_o,
  output logic                   valid_o,
  output logic [DATA_WIDTH-1:0]  result_o,
  output logic [RADDR_WIDTH-1:0] reg_waddr_o,
  output logic                   reg_we_o
);
  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(W + 1);
  localparam logic [CW-1:0] CNT_INIT = CW'(W);
  localparam logic [CW-1:0] CNT_LAST = CW'(1);
  localparam logic [W-1:0]  INT_MIN  = {1'b1, {(W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_e;

  state_e                 state_q, state_d;
  logic [2:0]             op_q;
  logic                   neg_q;
  logic [W-1:0]           magB_q;
  logic [W-1:0]           hi_q, lo_q;
  logic [W-1:0]           result_q;
  logic [CW-1:0]          cnt_q;
  logic [RADDR_WIDTH-1:0] waddr_q, waddrOut_q;

  logic           isDiv, op1Signed, op2Signed, sign1, sign2;
  logic           divZero, divOvf, fastMul, special, accept, negStart;
  logic [W-1:0]   mag1, mag2, specialRes;
  logic [2*W-1:0] fastProd;

  logic [W:0]     addSum, remShift, diff;
  logic [W-1:0]   hiNext, loNext, divVal, calcRes;

  // Apply sign to a 2W-bit magnitude product and pick the low word (MUL) or high word.
  function automatic logic [W-1:0] mulSelect(input logic [1:0] sel, input logic neg,
                                             input logic [2*W-1:0] prod);
    logic [2*W-1:0] p;
    p = neg ? -prod : prod;
    return (sel == 2'b00) ? p[W-1:0] : p[2*W-1:W];
  endfunction

  always_comb begin
    isDiv     = op_i[2];
    op1Signed = isDiv ? !op_i[0] : (op_i[1:0] != 2'b11);
    op2Signed = isDiv ? !op_i[0] : !op_i[1];
    sign1     = op1Signed & op1_i[W-1];
    sign2     = op2Signed & op2_i[W-1];
    mag1      = sign1 ? -op1_i : op1_i;
    mag2      = sign2 ? -op2_i : op2_i;
    negStart  = (isDiv & op_i[1]) ? sign1 : (sign1 ^ sign2);
    divZero   = isDiv & (op2_i == {W{1'b0}});
    divOvf    = isDiv & !op_i[0] & (op1_i == INT_MIN) & (op2_i == {W{1'b1}});
    fastMul   = FAST_MUL & !isDiv;
    special   = divZero | divOvf | fastMul;
    accept    = (state_q == IDLE) & start_i & !flush_i;
    fastProd  = {{W{1'b0}}, mag1} * {{W{1'b0}}, mag2};
    if (divZero) begin
      specialRes = op_i[1] ? op1_i : {W{1'b1}};
    end else if (divOvf) begin
      specialRes = op_i[1] ? {W{1'b0}} : op1_i;
    end else begin
      specialRes = mulSelect(op_i[1:0], sign1 ^ sign2, fastProd);
    end
  end

  // hi/lo hold the running product, or the partial remainder and the quotient shifting in.
  always_comb begin
    addSum   = {1'b0, hi_q} + {1'b0, (lo_q[0] ? magB_q : {W{1'b0}})};
    remShift = {hi_q, lo_q[W-1]};
    diff     = remShift - {1'b0, magB_q};
    if (op_q[2]) begin
      hiNext = diff[W] ? remShift[W-1:0] : diff[W-1:0];
      loNext = {lo_q[W-2:0], !diff[W]};
    end else begin
      hiNext = addSum[W:1];
      loNext = {addSum[0], lo_q[W-1:1]};
    end
    divVal  = op_q[1] ? hiNext : loNext;
    calcRes = op_q[2] ? (neg_q ? -divVal : divVal)
                      : mulSelect(op_q[1:0], neg_q, {hiNext, loNext});
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept) state_d = special ? DONE : CALC;
      CALC: begin
        if (flush_i) begin
          state_d = IDLE;
        end else if (cnt_q == CNT_LAST) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // A flush arriving in DONE kills the pulse, so the valid path is not purely registered.
  always_comb begin
    busy_o     = (state_q != IDLE);
    stallreq_o = rst_n_i & (accept | (state_q == CALC));
    valid_o    = (state_q == DONE) & !flush_i;
    reg_we_o   = valid_o;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      op_q       <= 3'b000;
      neg_q      <= 1'b0;
      magB_q     <= {W{1'b0}};
      hi_q       <= {W{1'b0}};
      lo_q       <= {W{1'b0}};
      cnt_q      <= {CW{1'b0}};
      waddr_q    <= {RADDR_WIDTH{1'b0}};
      waddrOut_q <= {RADDR_WIDTH{1'b0}};
      result_q   <= {W{1'b0}};
    end else if (accept) begin
      op_q    <= op_i;
      neg_q   <= negStart;
      magB_q  <= mag2;
      hi_q    <= {W{1'b0}};
      lo_q    <= mag1;
      cnt_q   <= CNT_INIT;
      waddr_q <= reg_waddr_i;
      if (special) begin
        result_q   <= specialRes;
        waddrOut_q <= reg_waddr_i;
      end
    end else if ((state_q == CALC) && !flush_i) begin
      hi_q  <= hiNext;
      lo_q  <= loNext;
      cnt_q <= cnt_q - CNT_LAST;
      if (cnt_q == CNT_LAST) begin
        result_q   <= calcRes;
        waddrOut_q <= waddr_q;
      end
    end
  end

  assign result_o    = result_q;
  assign reg_waddr_o = waddrOut_q;

endmodule

// File: tb/tb_exe_muldiv.sv
// Directed bench for exe_muldiv: one iterative instance and one FAST_MUL instance driven in
// parallel, checking results, latency, stall/write-enable shape, flush and reset behaviour.
module tb_exe_muldiv;
  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  op = 3'b000;
  logic [31:0] op1 = '0;
  logic [31:0] op2 = '0;
  logic [4:0]  waddr = '0;
  logic        flush = 1'b0;

  logic        busyS, stallS, validS, weS;
  logic [31:0] resS;
  logic [4:0]  waddrS;
  logic        busyF, stallF, validF, weF;
  logic [31:0] resF;
  logic [4:0]  waddrF;

  int testCount = 0;
  int failCount = 0;

  always #5 clk = ~clk;

  exe_muldiv #(.DATA_WIDTH(32), .RADDR_WIDTH(5), .FAST_MUL(1'b0)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(start), .op_i(op), .op1_i(op1), .op2_i(op2),
    .reg_waddr_i(waddr), .flush_i(flush), .busy_o(busyS), .stallreq_o(stallS),
    .valid_o(validS), .result_o(resS), .reg_waddr_o(waddrS), .reg_we_o(weS)
  );

  exe_muldiv #(.DATA_WIDTH(32), .RADDR_WIDTH(5), .FAST_MUL(1'b1)) dutFast (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(start), .op_i(op), .op1_i(op1), .op2_i(op2),
    .reg_waddr_i(waddr), .flush_i(flush), .busy_o(busyF), .stallreq_o(stallF),
    .valid_o(validF), .result_o(resF), .reg_waddr_o(waddrF), .reg_we_o(weF)
  );

  task automatic checkOutput(input string tag, input logic [63:0] actual,
                             input logic [63:0] expected);
    testCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Issue one op at cycle 0 and watch both instances for 40 cycles. stallCyc is the number of
  // leading cycles with stallreq high; a latency of -1 means no valid pulse is expected.
  task automatic applyStimulus(input string tag, input logic [2:0] opV, input logic [31:0] a,
                               input logic [31:0] b, input logic [4:0] wa,
                               input logic [31:0] expRes, input int expLatS, input int expLatF,
                               input int stallCycS, input int stallCycF,
                               input int flushAt, input int restartAt);
    int nS, nF, latS, latF, ctlS, ctlF, busyAfter;
    logic [31:0] gotS, gotF;
    logic [4:0]  gotWaS, gotWaF;
    nS = 0; nF = 0; latS = -1; latF = -1; ctlS = 0; ctlF = 0; busyAfter = 0;
    gotS = '0; gotF = '0; gotWaS = '0; gotWaF = '0;
    @(negedge clk);
    for (int c = 0; c < 40; c++) begin
      if (c == 0) begin
        start = 1'b1; op = opV; op1 = a; op2 = b; waddr = wa;
      end
      if (c == restartAt) begin
        start = 1'b1; op = 3'b000; op1 = 32'h11; op2 = 32'h22; waddr = 5'd30;
      end
      flush = (c == flushAt);
      #1;
      if (validS) begin nS++; latS = c; gotS = resS; gotWaS = waddrS; end
      if (validF) begin nF++; latF = c; gotF = resF; gotWaF = waddrF; end
      if (stallS !== (c < stallCycS)) ctlS++;
      if (stallF !== (c < stallCycF)) ctlF++;
      if (weS !== validS) ctlS++;
      if (weF !== validF) ctlF++;
      if (flushAt >= 0 && c == flushAt + 1) busyAfter = int'(busyS | busyF);
      @(negedge clk);
      start = 1'b0;
      flush = 1'b0;
    end
    checkOutput($sformatf("%s.slow.nvalid", tag), nS, (expLatS < 0) ? 0 : 1);
    checkOutput($sformatf("%s.fast.nvalid", tag), nF, (expLatF < 0) ? 0 : 1);
    checkOutput($sformatf("%s.slow.ctl", tag), ctlS, 0);
    checkOutput($sformatf("%s.fast.ctl", tag), ctlF, 0);
    if (expLatS >= 0) begin
      checkOutput($sformatf("%s.slow.lat", tag), latS, expLatS);
      checkOutput($sformatf("%s.slow.res", tag), gotS, expRes);
      checkOutput($sformatf("%s.slow.waddr", tag), gotWaS, wa);
    end
    if (expLatF >= 0) begin
      checkOutput($sformatf("%s.fast.lat", tag), latF, expLatF);
      checkOutput($sformatf("%s.fast.res", tag), gotF, expRes);
      checkOutput($sformatf("%s.fast.waddr", tag), gotWaF, wa);
    end
    if (flushAt >= 0) checkOutput($sformatf("%s.busy_after_flush", tag), busyAfter, 0);
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #12;
    checkOutput("reset.init.slow", {busyS, stallS, validS, weS, resS, waddrS}, 64'd0);
    checkOutput("reset.init.fast", {busyF, stallF, validF, weF, resF, waddrF}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Iterative divides: valid at cycle 33 on both instances
    applyStimulus("divu_100_7", 3'b101, 32'd100, 32'd7, 5'd5, 32'd14, 33, 33, 33, 33, -1, -1);
    applyStimulus("div_m7_2", 3'b100, 32'hFFFF_FFF9, 32'd2, 5'd6, 32'hFFFF_FFFD, 33, 33, 33, 33, -1, -1);
    applyStimulus("rem_m7_2", 3'b110, 32'hFFFF_FFF9, 32'd2, 5'd7, 32'hFFFF_FFFF, 33, 33, 33, 33, -1, -1);
    applyStimulus("div_7_m2", 3'b100, 32'd7, 32'hFFFF_FFFE, 5'd8, 32'hFFFF_FFFD, 33, 33, 33, 33, -1, -1);
    applyStimulus("rem_7_m2", 3'b110, 32'd7, 32'hFFFF_FFFE, 5'd9, 32'd1, 33, 33, 33, 33, -1, -1);
    applyStimulus("remu_100_7", 3'b111, 32'd100, 32'd7, 5'd10, 32'd2, 33, 33, 33, 33, -1, -1);
    applyStimulus("divu_max_1", 3'b101, 32'hFFFF_FFFF, 32'd1, 5'd11, 32'hFFFF_FFFF, 33, 33, 33, 33, -1, -1);

    // Divide corner cases finish at cycle 1
    applyStimulus("divu_by0", 3'b101, 32'd1234, 32'd0, 5'd12, 32'hFFFF_FFFF, 1, 1, 1, 1, -1, -1);
    applyStimulus("rem_9_by0", 3'b110, 32'd9, 32'd0, 5'd13, 32'd9, 1, 1, 1, 1, -1, -1);
    applyStimulus("remu_by0", 3'b111, 32'hDEAD_BEEF, 32'd0, 5'd14, 32'hDEAD_BEEF, 1, 1, 1, 1, -1, -1);
    applyStimulus("div_ovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15, 32'h8000_0000, 1, 1, 1, 1, -1, -1);
    applyStimulus("rem_ovf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd16, 32'd0, 1, 1, 1, 1, -1, -1);

    // Multiplies: cycle 33 iterative, cycle 1 with the fast multiplier
    applyStimulus("mulh_min_min", 3'b001, 32'h8000_0000, 32'h8000_0000, 5'd17, 32'h4000_0000, 33, 1, 33, 1, -1, -1);
    applyStimulus("mulhsu_m1", 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd18, 32'hFFFF_FFFF, 33, 1, 33, 1, -1, -1);
    applyStimulus("mulhu_max", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd19, 32'hFFFF_FFFE, 33, 1, 33, 1, -1, -1);
    applyStimulus("mul_3_m4", 3'b000, 32'd3, 32'hFFFF_FFFC, 5'd20, 32'hFFFF_FFF4, 33, 1, 33, 1, -1, -1);
    applyStimulus("mulhu_2p16", 3'b011, 32'h0001_0000, 32'h0001_0000, 5'd21, 32'd1, 33, 1, 33, 1, -1, -1);
    applyStimulus("mul_2p16", 3'b000, 32'h0001_0000, 32'h0001_0000, 5'd22, 32'd0, 33, 1, 33, 1, -1, -1);

    // Flush and start rules
    applyStimulus("flush_c10", 3'b101, 32'd100, 32'd7, 5'd23, 32'd0, -1, -1, 11, 11, 10, -1);
    applyStimulus("start_flush_idle", 3'b101, 32'd100, 32'd7, 5'd24, 32'd0, -1, -1, 0, 0, 0, -1);
    applyStimulus("start_in_calc", 3'b101, 32'd100, 32'd7, 5'd25, 32'd14, 33, 33, 33, 33, -1, 5);

    // Asynchronous reset in the middle of a DIV
    begin
      int nValid, nBusy;
      nValid = 0; nBusy = 0;
      @(negedge clk);
      start = 1'b1; op = 3'b100; op1 = 32'd100; op2 = 32'd7; waddr = 5'd9;
      @(negedge clk);
      start = 1'b0;
      repeat (14) @(negedge clk);
      #1;
      checkOutput("reset.mid.pre_busy", {busyS, busyF}, 64'd3);
      #1 rst_n = 1'b0;
      #1;
      checkOutput("reset.mid.slow", {busyS, stallS, validS, weS, resS, waddrS}, 64'd0);
      checkOutput("reset.mid.fast", {busyF, stallF, validF, weF, resF, waddrF}, 64'd0);
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      for (int c = 0; c < 40; c++) begin
        #1;
        if (validS || validF) nValid++;
        if (busyS || busyF) nBusy++;
        @(negedge clk);
      end
      checkOutput("reset.after.nvalid", nValid, 0);
      checkOutput("reset.after.busy", nBusy, 0);
    end
    applyStimulus("post_reset_divu", 3'b101, 32'd100, 32'd7, 5'd5, 32'd14, 33, 33, 33, 33, -1, -1);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
